// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: branch resolve, req/ack data-memory access, MEM/WB register.
// Optional MEM_MISALIGN_CHECK_EN retires misaligned loads/stores as flagged no-ops without touching memory.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_regWrite_ex_mem,
  input  logic        ctrl_memToReg_ex_mem,
  input  logic        ctrl_branch_ex_mem,
  input  logic        ctrl_memRead_ex_mem,
  input  logic        ctrl_memWrite_ex_mem,
  input  logic        zero_ex_mem,
  input  logic [31:0] branch_or_not_address_ex_mem,
  input  logic [31:0] alu_result_ex_mem,
  input  logic [31:0] read_data_2_ex_mem,
  input  logic [4:0]  write_register_ex_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_mem,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        ctrl_regWrite_mem_wb,
  output logic        ctrl_memToReg_mem_wb,
  output logic [31:0] read_data_mem_wb,
  output logic [31:0] alu_result_mem_wb,
  output logic [4:0]  write_register_mem_wb,
  output logic        misalign_mem_wb
);

  // state  | meaning
  // IDLE   | pass-through; a mem_op here raises the request on the next edge
  // ACCESS | request outstanding, waiting for dmem_ack
  // DONE   | access finished; instruction retires to MEM/WB on the next edge
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        rw_q, rw_d, mtr_q, mtr_d, mis_q, mis_d;
  logic [31:0] rd_q, rd_d, alu_q, alu_d;
  logic [4:0]  wr_q, wr_d;
  logic        mem_op, misalign;

  assign mem_op = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;
`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign = mem_op & (alu_result_ex_mem[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rw_d      = 1'b0;
    mtr_d     = 1'b0;
    mis_d     = 1'b0;
    rd_d      = 32'd0;
    alu_d     = 32'd0;
    wr_d      = 5'd0;
    stall_mem = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (misalign) begin
          mis_d = 1'b1;
          alu_d = alu_result_ex_mem;
          wr_d  = write_register_ex_mem;
        end else if (mem_op) begin
          stall_mem = 1'b1;
          req_d     = 1'b1;
          we_d      = ctrl_memWrite_ex_mem;
          addr_d    = {alu_result_ex_mem[31:2], 2'b00};
          wdata_d   = read_data_2_ex_mem;
          rdata_d   = 32'd0;
          state_d   = S_ACCESS;
        end else begin
          rw_d  = ctrl_regWrite_ex_mem;
          mtr_d = ctrl_memToReg_ex_mem;
          alu_d = alu_result_ex_mem;
          wr_d  = write_register_ex_mem;
        end
      end
      S_ACCESS: begin
        stall_mem = 1'b1;
        if (dmem_ack) begin
          req_d   = 1'b0;
          rdata_d = we_q ? 32'd0 : dmem_rdata;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        rw_d    = ctrl_regWrite_ex_mem;
        mtr_d   = ctrl_memToReg_ex_mem;
        rd_d    = rdata_q;
        alu_d   = alu_result_ex_mem;
        wr_d    = write_register_ex_mem;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      rw_q    <= 1'b0;
      mtr_q   <= 1'b0;
      mis_q   <= 1'b0;
      rd_q    <= 32'd0;
      alu_q   <= 32'd0;
      wr_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      mtr_q   <= mtr_d;
      mis_q   <= mis_d;
      rd_q    <= rd_d;
      alu_q   <= alu_d;
      wr_q    <= wr_d;
    end
  end

  // Gating by stall keeps a held branch from redirecting more than once.
  assign pc_src                = ctrl_branch_ex_mem & zero_ex_mem & ~stall_mem;
  assign branch_target         = branch_or_not_address_ex_mem;
  assign dmem_req              = req_q;
  assign dmem_we               = we_q;
  assign dmem_addr             = addr_q;
  assign dmem_wdata            = wdata_q;
  assign ctrl_regWrite_mem_wb  = rw_q;
  assign ctrl_memToReg_mem_wb  = mtr_q;
  assign read_data_mem_wb      = rd_q;
  assign alu_result_mem_wb     = alu_q;
  assign write_register_mem_wb = wr_q;
  assign misalign_mem_wb       = mis_q;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, directly downstream of the EX/MEM register. It resolves the branch decision, performs data-memory loads and stores over a req/ack handshake with variable latency, and stalls upstream stages while an access is outstanding. It owns the MEM/WB pipeline register and feeds the write-back stage.

## Interface
No parameters. Data width is fixed at 32 bits and register index width at 5 bits.
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-low
- ctrl_regWrite_ex_mem, ctrl_memToReg_ex_mem, ctrl_branch_ex_mem, ctrl_memRead_ex_mem, ctrl_memWrite_ex_mem  in  1 each  control bits from EX/MEM
- zero_ex_mem  in  1  ALU zero flag
- branch_or_not_address_ex_mem  in  32  branch target
- alu_result_ex_mem  in  32  memory address, or result for R-type instructions
- read_data_2_ex_mem  in  32  store data
- write_register_ex_mem  in  5  destination register
- dmem_req  out  1  access request, registered
- dmem_we  out  1  1 = store, registered
- dmem_addr  out  32  word address {alu[31:2],2'b00}, registered
- dmem_wdata  out  32  store data, registered
- dmem_rdata  in  32  load data, valid when dmem_ack=1
- dmem_ack  in  1  access complete, single-cycle pulse
- stall_mem  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM
- pc_src  out  1  combinational; ctrl_branch & zero & ~stall_mem
- branch_target  out  32  combinational; equals branch_or_not_address_ex_mem
- ctrl_regWrite_mem_wb, ctrl_memToReg_mem_wb  out  1  MEM/WB control bits
- read_data_mem_wb, alu_result_mem_wb  out  32  MEM/WB data
- write_register_mem_wb  out  5  MEM/WB destination
- misalign_mem_wb  out  1  instruction in MEM/WB was a misaligned access

## Operation
- A memory operation (mem_op) is memRead | memWrite. If both are set, memWrite wins and the instruction is treated as a store.
- The FSM has three states: IDLE, ACCESS and DONE.
- IDLE, no mem_op:
  - stall_mem = 0.
  - On each edge, MEM/WB captures the EX/MEM fields, with read_data = 0.
- IDLE, mem_op:
  - stall_mem = 1.
  - On the next edge: dmem_req goes to 1; dmem_we, dmem_addr and dmem_wdata are latched; the state moves to ACCESS; MEM/WB takes a bubble.
- ACCESS:
  - stall_mem = 1 and dmem_req is held at 1.
  - On an edge with dmem_ack = 1: dmem_req goes to 0, dmem_rdata is latched into rdata_q (loads only; stores leave rdata_q at 0), and the state moves to DONE.
  - MEM/WB takes a bubble on every ACCESS edge.
- DONE:
  - stall_mem = 0.
  - On the next edge, MEM/WB captures the instruction with read_data = rdata_q, and the state returns to IDLE.
- A bubble means all MEM/WB outputs are 0, so ctrl_regWrite_mem_wb = 0.
- dmem_ack is ignored in IDLE and DONE.
- pc_src is gated by ~stall_mem, so a redirect is seen exactly once.
- On reset assertion, at any time including mid-access:
  - The state goes to IDLE.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata, rdata_q and all MEM/WB outputs go to 0.
  - A late ack after reset is ignored.

## Timing
- Non-memory instruction: 1 cycle in MEM, with no stall.
- Load or store with memory latency L (ack on the L-th edge after req rises, L ≥ 1):
  - stall_mem is high for L+1 cycles.
  - The instruction retires to MEM/WB on edge L+2.
- Zero-wait memory (L = 1): a 3-cycle occupancy.
- Back-to-back memory instructions: DONE is followed by IDLE, which immediately sees the next mem_op. There are no lost cycles beyond the stalls above.
- The EX/MEM inputs must stay stable while stall_mem = 1. Upstream guarantees this.

## Configuration
- MEM_MISALIGN_CHECK_EN defined:
  - A mem_op with alu_result[1:0] ≠ 0 issues no request and causes no stall.
  - It retires in 1 cycle with ctrl_regWrite_mem_wb forced to 0, ctrl_memToReg_mem_wb = 0, and misalign_mem_wb = 1 for that slot.
- MEM_MISALIGN_CHECK_EN undefined:
  - alu_result[1:0] is ignored; the word-aligned address is used.
  - misalign_mem_wb is tied to 0.

## Test plan
- R-type: alu=0x0000_1234, regWrite=1, wr=5, no mem_op -> next edge: alu_result_mem_wb=0x1234, write_register_mem_wb=5, regWrite=1, stall_mem stays 0.
- Load at addr 0x40, memory returns 0xDEADBEEF with L=3 -> stall_mem high 4 cycles, dmem_addr=0x40, dmem_we=0; MEM/WB bubbles, then read_data_mem_wb=0xDEADBEEF, memToReg=1, on edge 5.
- Store of 0xCAFEF00D to 0x80 with L=1 -> dmem_we=1, dmem_wdata=0xCAFEF00D, stall 2 cycles, ctrl_regWrite_mem_wb=0 at retire.
- Branch with zero=1, target=0x0000_0100 -> pc_src=1, branch_target=0x100 in the same cycle; with zero=0 -> pc_src=0.
- Reset pulled low in ACCESS, then ack arrives after release -> dmem_req=0, all MEM/WB outputs 0, FSM in IDLE, the ack has no effect.
- MEM_MISALIGN_CHECK_EN defined, load at 0x42 -> no dmem_req, no stall, misalign_mem_wb=1, ctrl_regWrite_mem_wb=0.
